// File: rtl/lsu_exec_queue_pkg.sv
// Shared definitions for the load/store execution stage: opcode ids, widths,
// FSM state encodings and opcode decode helpers.
package lsu_exec_queue_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned RobIdBus  = 4;
    localparam int unsigned OpIdBus   = 6;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    typedef logic [OpIdBus-1:0] op_id_t;

    localparam op_id_t OpLb  = 6'd11;
    localparam op_id_t OpLh  = 6'd12;
    localparam op_id_t OpLw  = 6'd13;
    localparam op_id_t OpLbu = 6'd14;
    localparam op_id_t OpLhu = 6'd15;
    localparam op_id_t OpSb  = 6'd16;
    localparam op_id_t OpSh  = 6'd17;
    localparam op_id_t OpSw  = 6'd18;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StDrain = 2'd2
    } lsu_state_e;

    function automatic logic op_is_load(input op_id_t op);
        case (op)
            OpLb, OpLh, OpLw, OpLbu, OpLhu: return True;
            default:                        return False;
        endcase
    endfunction

    function automatic logic op_is_store(input op_id_t op);
        case (op)
            OpSb, OpSh, OpSw: return True;
            default:          return False;
        endcase
    endfunction

    // Byte accesses can never be misaligned.
    function automatic logic op_misaligned(input op_id_t op, input logic [1:0] ea_lo);
        case (op)
            OpLh, OpLhu, OpSh: return ea_lo[0];
            OpLw, OpSw:        return ea_lo != 2'b00;
            default:           return False;
        endcase
    endfunction

endpackage

// File: rtl/lsu_exec_queue_load_fifo.sv
// Circular FIFO holding pending loads; flush empties it in one cycle.
module lsu_load_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    always_comb begin
        full    = count_q == CntW'(DEPTH);
        empty   = count_q == '0;
        do_pop  = pop & !empty;
        // A push into a full queue is only legal when the head leaves this cycle.
        do_push = push & (!full | do_pop);
        rdata   = mem_q[rd_ptr_q];
        count   = count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (en) begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en && !flush && do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/lsu_exec_queue.sv
// Load/store execution stage: address generation, alignment check, in-order load
// queue with one outstanding MC load, single held store, result write to the ROB.
module lsu_exec_queue
    import lsu_exec_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DataWidth,
    parameter int unsigned ROB_ID_WIDTH = RobIdBus,
    parameter int unsigned OP_ID_WIDTH  = OpIdBus,
    parameter int unsigned LQ_DEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    lsb_valid,
    input  logic [OP_ID_WIDTH-1:0]  lsb_op_id,
    input  logic [DATA_WIDTH-1:0]   lsb_rs1,
    input  logic [DATA_WIDTH-1:0]   lsb_rs2,
    input  logic [DATA_WIDTH-1:0]   lsb_imm,
    input  logic [ROB_ID_WIDTH-1:0] lsb_rob_id,
    output logic                    lsb_ready,
    output logic                    rob_valid,
    output logic [ROB_ID_WIDTH-1:0] rob_rob_id,
    output logic [DATA_WIDTH-1:0]   rob_value,
    output logic [DATA_WIDTH-1:0]   rob_addr,
    output logic                    rob_misaligned,
    input  logic                    mc_msb_full,
    output logic                    mc_need_load,
    output logic [OP_ID_WIDTH-1:0]  mc_op_id,
    output logic [DATA_WIDTH-1:0]   mc_load_addr,
    input  logic                    mc_finish_load,
    input  logic [DATA_WIDTH-1:0]   mc_value,
    input  logic                    rob_roll_back
);
    localparam int unsigned EntryW = OP_ID_WIDTH + DATA_WIDTH + ROB_ID_WIDTH + 1;
    localparam int unsigned CntW   = $clog2(LQ_DEPTH + 1);

    lsu_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0]   in_ea;
    logic                    in_is_load, in_is_store, in_mis;
    logic                    accept, st_new, st_direct, st_slot_go;

    logic [EntryW-1:0]       lq_wdata, lq_rdata;
    logic                    lq_full, lq_empty, lq_push, lq_pop, lq_flush;
    logic [CntW-1:0]         lq_count;
    logic [OP_ID_WIDTH-1:0]  head_op;
    logic [DATA_WIDTH-1:0]   head_addr;
    logic [ROB_ID_WIDTH-1:0] head_rob;
    logic                    head_mis;

    logic                    mc_req, ld_done, mis_pop, load_res;
    logic [DATA_WIDTH-1:0]   ld_data;

    logic                    st_busy_q, st_mis_q;
    logic [DATA_WIDTH-1:0]   st_value_q, st_addr_q;
    logic [ROB_ID_WIDTH-1:0] st_rob_q;

    logic                    res_valid, res_mis;
    logic [ROB_ID_WIDTH-1:0] res_rob;
    logic [DATA_WIDTH-1:0]   res_value, res_addr;

    logic                    rob_valid_q, rob_mis_q;
    logic [ROB_ID_WIDTH-1:0] rob_id_q;
    logic [DATA_WIDTH-1:0]   rob_value_q, rob_addr_q;

    always_comb begin
        in_ea       = lsb_rs1 + lsb_imm;
        in_is_load  = op_is_load(op_id_t'(lsb_op_id));
        in_is_store = op_is_store(op_id_t'(lsb_op_id));
        in_mis      = op_misaligned(op_id_t'(lsb_op_id), in_ea[1:0]);
        lsb_ready   = rdy & !lq_full & !st_busy_q;
        accept      = lsb_valid & lsb_ready & !rob_roll_back;
        st_new      = accept & in_is_store;
        lq_push     = accept & in_is_load;
        lq_wdata    = {lsb_op_id, in_ea, lsb_rob_id, in_mis};
    end

    assign {head_op, head_addr, head_rob, head_mis} = lq_rdata;

    lsu_load_fifo #(
        .WIDTH (EntryW),
        .DEPTH (LQ_DEPTH)
    ) u_load_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (rdy),
        .push  (lq_push),
        .pop   (lq_pop),
        .flush (lq_flush),
        .wdata (lq_wdata),
        .rdata (lq_rdata),
        .full  (lq_full),
        .empty (lq_empty),
        .count (lq_count)
    );

    always_comb begin
        state_d = state_q;
        mc_req  = 1'b0;
        ld_done = 1'b0;
        mis_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!lq_empty) begin
                    if (head_mis) begin
                        mis_pop = 1'b1;
                    end else begin
                        mc_req  = 1'b1;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (mc_finish_load) begin
                    ld_done = 1'b1;
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (mc_finish_load) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (rob_roll_back) begin
            mc_req  = 1'b0;
            ld_done = 1'b0;
            mis_pop = 1'b0;
            // A finish arriving with the rollback retires the outstanding load already.
            if ((state_q == StWait || state_q == StDrain) && !mc_finish_load) begin
                state_d = StDrain;
            end else begin
                state_d = StIdle;
            end
        end
        load_res = ld_done | mis_pop;
        lq_pop   = load_res;
        lq_flush = rob_roll_back;
    end

    always_comb begin
        ld_data = mc_value;
        case (op_id_t'(head_op))
            OpLb:    ld_data = {{(DATA_WIDTH-8){mc_value[7]}}, mc_value[7:0]};
            OpLbu:   ld_data = {{(DATA_WIDTH-8){1'b0}}, mc_value[7:0]};
            OpLh:    ld_data = {{(DATA_WIDTH-16){mc_value[15]}}, mc_value[15:0]};
            OpLhu:   ld_data = {{(DATA_WIDTH-16){1'b0}}, mc_value[15:0]};
            default: ld_data = mc_value;
        endcase
    end

    always_comb begin
        mc_need_load = rdy & mc_req;
        mc_op_id     = mc_need_load ? head_op : '0;
        mc_load_addr = mc_need_load ? head_addr : '0;
    end

    // Result port: load result first, then the held store, then a store straight from the LSB.
    always_comb begin
        res_valid  = 1'b0;
        res_mis    = 1'b0;
        res_rob    = '0;
        res_value  = '0;
        res_addr   = '0;
        st_slot_go = st_busy_q & (st_mis_q | !mc_msb_full) & !load_res;
        st_direct  = st_new & (in_mis | !mc_msb_full) & !load_res;
        if (load_res) begin
            res_valid = 1'b1;
            res_mis   = mis_pop;
            res_rob   = head_rob;
            res_value = ld_done ? ld_data : '0;
            res_addr  = head_addr;
        end else if (st_slot_go) begin
            res_valid = 1'b1;
            res_mis   = st_mis_q;
            res_rob   = st_rob_q;
            res_value = st_value_q;
            res_addr  = st_addr_q;
        end else if (st_direct) begin
            res_valid = 1'b1;
            res_mis   = in_mis;
            res_rob   = lsb_rob_id;
            res_value = lsb_rs2;
            res_addr  = in_ea;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            st_busy_q   <= 1'b0;
            st_mis_q    <= 1'b0;
            st_rob_q    <= '0;
            st_value_q  <= '0;
            st_addr_q   <= '0;
            rob_valid_q <= 1'b0;
            rob_mis_q   <= 1'b0;
            rob_id_q    <= '0;
            rob_value_q <= '0;
            rob_addr_q  <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            if (rob_roll_back) begin
                st_busy_q   <= 1'b0;
                rob_valid_q <= 1'b0;
                rob_mis_q   <= 1'b0;
            end else begin
                rob_valid_q <= res_valid;
                rob_mis_q   <= res_valid & res_mis;
                if (res_valid) begin
                    rob_id_q    <= res_rob;
                    rob_value_q <= res_value;
                    rob_addr_q  <= res_addr;
                end
                if (st_slot_go) begin
                    st_busy_q <= 1'b0;
                end else if (st_new && !st_direct) begin
                    st_busy_q  <= 1'b1;
                    st_mis_q   <= in_mis;
                    st_rob_q   <= lsb_rob_id;
                    st_value_q <= lsb_rs2;
                    st_addr_q  <= in_ea;
                end
            end
        end
    end

    always_comb begin
        rob_valid      = rdy & rob_valid_q;
        rob_rob_id     = rob_id_q;
        rob_value      = rob_value_q;
        rob_addr       = rob_addr_q;
        rob_misaligned = rob_mis_q;
    end

    lq_count_consistent: assert property (@(posedge clk) disable iff (rst)
        lq_full == (lq_count == CntW'(LQ_DEPTH)));

endmodule

// File: tb/tb_lsu_exec_queue.sv
// Directed bench for lsu_exec_queue: vector table of single transactions plus
// hand-written queue-full, store backpressure, rollback and reset sequences.
module tb_lsu_exec_queue;
    import lsu_exec_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, lsb_valid, mc_msb_full, mc_finish_load, rob_roll_back;
    logic [5:0]  lsb_op_id;
    logic [31:0] lsb_rs1, lsb_rs2, lsb_imm, mc_value;
    logic [3:0]  lsb_rob_id;
    logic        lsb_ready, rob_valid, rob_misaligned, mc_need_load;
    logic [3:0]  rob_rob_id;
    logic [31:0] rob_value, rob_addr, mc_load_addr;
    logic [5:0]  mc_op_id;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] rs1, imm, rs2;
        logic [3:0]  tag;
        logic        msb;
        logic [31:0] mc_data;
        logic        is_load, exp_mis;
        logic [31:0] exp_addr, exp_value;
    } vec_t;

    vec_t vecs[10];

    lsu_exec_queue dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .lsb_valid      (lsb_valid),
        .lsb_op_id      (lsb_op_id),
        .lsb_rs1        (lsb_rs1),
        .lsb_rs2        (lsb_rs2),
        .lsb_imm        (lsb_imm),
        .lsb_rob_id     (lsb_rob_id),
        .lsb_ready      (lsb_ready),
        .rob_valid      (rob_valid),
        .rob_rob_id     (rob_rob_id),
        .rob_value      (rob_value),
        .rob_addr       (rob_addr),
        .rob_misaligned (rob_misaligned),
        .mc_msb_full    (mc_msb_full),
        .mc_need_load   (mc_need_load),
        .mc_op_id       (mc_op_id),
        .mc_load_addr   (mc_load_addr),
        .mc_finish_load (mc_finish_load),
        .mc_value       (mc_value),
        .rob_roll_back  (rob_roll_back)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] rs1, input logic [31:0] imm,
                         input logic [31:0] rs2, input logic [3:0] tag);
        lsb_valid  = 1'b1;
        lsb_op_id  = op;
        lsb_rs1    = rs1;
        lsb_imm    = imm;
        lsb_rs2    = rs2;
        lsb_rob_id = tag;
    endtask

    task automatic chk_rob(input string name, input logic [3:0] tag, input logic [31:0] value,
                           input logic [31:0] addr, input logic mis);
        chk1({name, "_valid"}, rob_valid, 1'b1);
        chk32({name, "_tag"}, {28'd0, rob_rob_id}, {28'd0, tag});
        chk32({name, "_value"}, rob_value, value);
        chk32({name, "_addr"}, rob_addr, addr);
        chk1({name, "_mis"}, rob_misaligned, mis);
    endtask

    task automatic wait_req(input string name, input logic [31:0] addr);
        int k = 0;
        while (!mc_need_load && k < 8) begin
            next();
            settle();
            k++;
        end
        chk1({name, "_req"}, mc_need_load, 1'b1);
        chk32({name, "_req_addr"}, mc_load_addr, addr);
    endtask

    task automatic finish_load(input logic [31:0] data);
        next();
        mc_finish_load = 1'b1;
        mc_value       = data;
        settle();
        next();
        mc_finish_load = 1'b0;
        mc_value       = '0;
        settle();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string p;
        p = $sformatf("vec%0d", idx);
        next();
        drive(v.op, v.rs1, v.imm, v.rs2, v.tag);
        mc_msb_full = v.msb;
        settle();
        chk1({p, "_ready"}, lsb_ready, 1'b1);
        next();
        lsb_valid   = 1'b0;
        mc_msb_full = 1'b0;
        settle();
        if (v.is_load && !v.exp_mis) begin
            chk1({p, "_req"}, mc_need_load, 1'b1);
            chk32({p, "_req_addr"}, mc_load_addr, v.exp_addr);
            chk32({p, "_req_op"}, {26'd0, mc_op_id}, {26'd0, v.op});
            next();
            settle();
            chk1({p, "_req_pulse"}, mc_need_load, 1'b0);
            next();
            next();
            mc_finish_load = 1'b1;
            mc_value       = v.mc_data;
            settle();
            chk1({p, "_no_early"}, rob_valid, 1'b0);
            next();
            mc_finish_load = 1'b0;
            mc_value       = '0;
            settle();
        end else if (v.is_load) begin
            chk1({p, "_mis_noreq"}, mc_need_load, 1'b0);
            next();
            settle();
        end
        chk_rob(p, v.tag, v.exp_value, v.exp_addr, v.exp_mis);
        next();
        settle();
        chk1({p, "_pulse"}, rob_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        lsb_valid = 1'b0;
        lsb_op_id = '0;
        lsb_rs1 = '0;
        lsb_rs2 = '0;
        lsb_imm = '0;
        lsb_rob_id = '0;
        mc_msb_full = 1'b0;
        mc_finish_load = 1'b0;
        mc_value = '0;
        rob_roll_back = 1'b0;

        vecs[0] = '{OpLw,  32'h1000, 32'h4, 32'h0, 4'd1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0,
                    32'h1004, 32'hDEADBEEF};
        vecs[1] = '{OpLb,  32'h2000, 32'h1, 32'h0, 4'd2, 1'b0, 32'h00000080, 1'b1, 1'b0,
                    32'h2001, 32'hFFFFFF80};
        vecs[2] = '{OpLbu, 32'h2000, 32'h2, 32'h0, 4'd3, 1'b0, 32'h00000080, 1'b1, 1'b0,
                    32'h2002, 32'h00000080};
        vecs[3] = '{OpLh,  32'h3000, 32'h2, 32'h0, 4'd4, 1'b0, 32'h00008001, 1'b1, 1'b0,
                    32'h3002, 32'hFFFF8001};
        vecs[4] = '{OpLhu, 32'h3000, 32'hFFFFFFFE, 32'h0, 4'd5, 1'b0, 32'h00018001, 1'b1, 1'b0,
                    32'h2FFE, 32'h00008001};
        vecs[5] = '{OpLw,  32'h1000, 32'h2, 32'h0, 4'd6, 1'b0, 32'h0, 1'b1, 1'b1,
                    32'h1002, 32'h0};
        vecs[6] = '{OpSh,  32'h0, 32'h3, 32'hBEEF, 4'd7, 1'b1, 32'h0, 1'b0, 1'b1,
                    32'h3, 32'hBEEF};
        vecs[7] = '{OpSw,  32'h100, 32'h20, 32'hCAFEF00D, 4'd8, 1'b0, 32'h0, 1'b0, 1'b0,
                    32'h120, 32'hCAFEF00D};
        vecs[8] = '{OpSb,  32'hFFFFFFFF, 32'h2, 32'h12345678, 4'd9, 1'b0, 32'h0, 1'b0, 1'b0,
                    32'h1, 32'h12345678};
        vecs[9] = '{OpLb,  32'h10, 32'h0, 32'h0, 4'd10, 1'b0, 32'hFFFFFF7F, 1'b1, 1'b0,
                    32'h10, 32'h0000007F};

        #12;
        chk1("reset_ready", lsb_ready, 1'b1);
        chk1("reset_rob_valid", rob_valid, 1'b0);
        chk1("reset_need_load", mc_need_load, 1'b0);
        chk32("reset_rob_value", rob_value, 32'h0);
        chk32("reset_rob_addr", rob_addr, 32'h0);
        chk1("reset_rob_mis", rob_misaligned, 1'b0);
        chk32("reset_mc_addr", mc_load_addr, 32'h0);
        settle();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Queue full: four loads while the MC is stalled, then in-order return.
        for (int i = 0; i < 4; i++) begin
            next();
            drive(OpLw, 32'h40, 32'(4 * i), 32'h0, 4'(4 + i));
            settle();
            chk1("qfull_accept_ready", lsb_ready, 1'b1);
            if (i == 1) begin
                chk1("qfull_first_req", mc_need_load, 1'b1);
                chk32("qfull_first_addr", mc_load_addr, 32'h40);
            end
        end
        next();
        lsb_valid = 1'b0;
        settle();
        chk1("qfull_ready_low", lsb_ready, 1'b0);
        chk1("qfull_no_second_req", mc_need_load, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) wait_req($sformatf("qfull%0d", i), 32'h40 + 32'(4 * i));
            finish_load(32'h100 + 32'(i));
            chk_rob($sformatf("qfull%0d", i), 4'(4 + i), 32'h100 + 32'(i),
                    32'h40 + 32'(4 * i), 1'b0);
            if (i == 0) chk1("qfull_ready_back", lsb_ready, 1'b1);
        end

        // Store held while the MSB is full, reported the cycle after it drains.
        next();
        drive(OpSw, 32'h600, 32'h8, 32'hA5A5, 4'd10);
        mc_msb_full = 1'b1;
        settle();
        chk1("st_bp_accept", lsb_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            next();
            lsb_valid = 1'b0;
            settle();
            chk1("st_bp_no_result", rob_valid, 1'b0);
            chk1("st_bp_ready_low", lsb_ready, 1'b0);
        end
        next();
        mc_msb_full = 1'b0;
        settle();
        chk1("st_bp_drop_cycle", rob_valid, 1'b0);
        next();
        settle();
        chk_rob("st_bp", 4'd10, 32'hA5A5, 32'h608, 1'b0);
        next();
        settle();
        chk1("st_bp_ready_back", lsb_ready, 1'b1);

        // Load completion and store release in the same cycle: the load wins the port.
        next();
        drive(OpLw, 32'h200, 32'h0, 32'h0, 4'd8);
        settle();
        next();
        drive(OpSw, 32'h300, 32'h0, 32'h55AA, 4'd9);
        mc_msb_full = 1'b1;
        settle();
        chk1("arb_req", mc_need_load, 1'b1);
        chk32("arb_req_addr", mc_load_addr, 32'h200);
        next();
        lsb_valid = 1'b0;
        settle();
        chk1("arb_st_held", lsb_ready, 1'b0);
        next();
        mc_msb_full    = 1'b0;
        mc_finish_load = 1'b1;
        mc_value       = 32'h777;
        settle();
        next();
        mc_finish_load = 1'b0;
        settle();
        chk_rob("arb_load", 4'd8, 32'h777, 32'h200, 1'b0);
        next();
        settle();
        chk_rob("arb_store", 4'd9, 32'h55AA, 32'h300, 1'b0);
        next();
        settle();
        chk1("arb_idle", rob_valid, 1'b0);

        // Rollback with one load outstanding and two queued behind it.
        next();
        drive(OpLw, 32'h400, 32'h0, 32'h0, 4'd1);
        settle();
        next();
        drive(OpLw, 32'h404, 32'h0, 32'h0, 4'd2);
        settle();
        chk1("rb_req", mc_need_load, 1'b1);
        chk32("rb_req_addr", mc_load_addr, 32'h400);
        next();
        drive(OpLw, 32'h408, 32'h0, 32'h0, 4'd3);
        settle();
        next();
        drive(OpLw, 32'h40C, 32'h0, 32'h0, 4'd4);
        rob_roll_back = 1'b1;
        settle();
        next();
        lsb_valid     = 1'b0;
        rob_roll_back = 1'b0;
        settle();
        chk1("rb_ready", lsb_ready, 1'b1);
        chk1("rb_no_result", rob_valid, 1'b0);
        chk1("rb_no_req", mc_need_load, 1'b0);
        next();
        drive(OpLw, 32'h500, 32'h0, 32'h0, 4'd5);
        settle();
        chk1("rb_drain_ready", lsb_ready, 1'b1);
        chk1("rb_drain_no_req0", mc_need_load, 1'b0);
        next();
        lsb_valid = 1'b0;
        settle();
        chk1("rb_drain_no_req1", mc_need_load, 1'b0);
        next();
        mc_finish_load = 1'b1;
        mc_value       = 32'hBAD;
        settle();
        chk1("rb_drain_no_req2", mc_need_load, 1'b0);
        next();
        mc_finish_load = 1'b0;
        settle();
        chk1("rb_discard", rob_valid, 1'b0);
        chk1("rb_new_req", mc_need_load, 1'b1);
        chk32("rb_new_req_addr", mc_load_addr, 32'h500);
        finish_load(32'h5);
        chk_rob("rb_new", 4'd5, 32'h5, 32'h500, 1'b0);
        for (int i = 0; i < 3; i++) begin
            next();
            settle();
            chk1("rb_flushed_no_req", mc_need_load, 1'b0);
        end

        // Asynchronous reset while a load is outstanding.
        next();
        drive(OpLw, 32'h700, 32'h0, 32'h0, 4'd6);
        settle();
        next();
        lsb_valid = 1'b0;
        settle();
        chk1("arst_req", mc_need_load, 1'b1);
        next();
        settle();
        #2 rst = 1'b1;
        #1;
        chk1("arst_ready", lsb_ready, 1'b1);
        chk1("arst_rob_valid", rob_valid, 1'b0);
        chk32("arst_rob_addr", rob_addr, 32'h0);
        chk32("arst_rob_value", rob_value, 32'h0);
        settle();
        rst = 1'b0;
        next();
        mc_finish_load = 1'b1;
        mc_value       = 32'h99;
        settle();
        chk1("arst_no_req", mc_need_load, 1'b0);
        next();
        mc_finish_load = 1'b0;
        settle();
        chk1("arst_late_finish", rob_valid, 1'b0);
        next();
        drive(OpLw, 32'h710, 32'h0, 32'h0, 4'd7);
        settle();
        next();
        lsb_valid = 1'b0;
        settle();
        chk1("arst_new_req", mc_need_load, 1'b1);
        chk32("arst_new_addr", mc_load_addr, 32'h710);
        finish_load(32'h1);
        chk_rob("arst_new", 4'd7, 32'h1, 32'h710, 1'b0);

        // Global enable low freezes the stage.
        next();
        rdy = 1'b0;
        drive(OpLw, 32'h800, 32'h0, 32'h0, 4'd3);
        settle();
        chk1("rdy0_ready", lsb_ready, 1'b0);
        chk1("rdy0_no_req", mc_need_load, 1'b0);
        next();
        settle();
        chk1("rdy0_no_req_hold", mc_need_load, 1'b0);
        next();
        rdy       = 1'b1;
        lsb_valid = 1'b0;
        settle();
        chk1("rdy1_nothing_queued", mc_need_load, 1'b0);
        chk1("rdy1_ready", lsb_ready, 1'b1);
        next();
        settle();
        chk1("rdy1_nothing_queued2", mc_need_load, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
